// File: rtl/mont_domain_enc.sv
// Bit-serial Montgomery-domain entry converter: res = op * 2^LOG_R mod q.
// One pre-reduction on capture, then LOG_R double-and-conditional-subtract steps.
module mont_domain_enc #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG_R      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] op_i,
  input  logic [DATA_WIDTH-1:0] q_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] res_o
);

  localparam int CW = $clog2(LOG_R + 1);
  localparam logic [CW-1:0] LAST = CW'(LOG_R - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] q_reg;

  logic                  accept;
  logic [DATA_WIDTH-1:0] pre_red;
  logic [DATA_WIDTH:0]   dbl;
  logic [DATA_WIDTH-1:0] shift_red;

  // A finished result may be swapped for a new operand in the same cycle.
  assign in_ready_o  = (state == IDLE) || ((state == DONE) && out_ready_i);
  assign out_valid_o = (state == DONE);
  assign res_o       = acc;
  assign accept      = in_valid_i && in_ready_o;

  assign pre_red   = (op_i >= q_i) ? (op_i - q_i) : op_i;
  // acc < q, so the doubled value fits in DATA_WIDTH+1 bits and the
  // reduced difference always fits back into DATA_WIDTH bits.
  assign dbl       = {acc, 1'b0};
  assign shift_red = (dbl >= {1'b0, q_reg}) ? (dbl[DATA_WIDTH-1:0] - q_reg)
                                            : dbl[DATA_WIDTH-1:0];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      count <= '0;
      acc   <= '0;
      q_reg <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            q_reg <= q_i;
            acc   <= pre_red;
            count <= '0;
            state <= SHIFT;
          end else if ((state == DONE) && out_ready_i) begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          acc <= shift_red;
          // Stop on the last step instead of incrementing, so count never reaches LOG_R.
          if (count == LAST) begin
            state <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_domain_enc.sv
// Scoreboard bench for mont_domain_enc: one instance with LOG_R=32, one with LOG_R=16.
// Expected results come from modular arithmetic and a Montgomery multiply round trip.
module tb_mont_domain_enc;

  localparam int DW = 32;

  typedef struct {
    longint unsigned exp;
    longint unsigned op_mod;
    longint unsigned q;
    int              acc_cyc;
    bit              chk_lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [DW-1:0] op        [2];
  logic [DW-1:0] q         [2];
  logic [DW-1:0] res       [2];

  exp_t sb0[$];
  exp_t sb1[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_hs [2];
  bit   b2b = 1'b0;
  bit   pv  [2];
  bit   pr  [2];
  logic [DW-1:0] pres [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mont_domain_enc #(.DATA_WIDTH(DW), .LOG_R(32)) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .op_i(op[0]), .q_i(q[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .res_o(res[0])
  );

  mont_domain_enc #(.DATA_WIDTH(DW), .LOG_R(16)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .op_i(op[1]), .q_i(q[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .res_o(res[1])
  );

  task automatic check(input string name, input longint unsigned got, input longint unsigned want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic int log_r_of(input int d);
    return (d == 0) ? 32 : 16;
  endfunction

  // op * 2^log_r mod q, straight from the definition.
  function automatic longint unsigned model(input longint unsigned o, input longint unsigned m,
                                            input int log_r);
    longint unsigned r_mod;
    r_mod = (64'd1 << log_r) % m;
    return ((o % m) * r_mod) % m;
  endfunction

  // a * b * 2^-log_r mod q via halving (odd q makes every step exact).
  function automatic longint unsigned mont_mul(input longint unsigned a, input longint unsigned b,
                                               input longint unsigned m, input int log_r);
    longint unsigned t;
    t = a * b;
    for (int i = 0; i < log_r; i++) begin
      if (t[0]) t = t + m;
      t = t >> 1;
    end
    while (t >= m) t = t - m;
    return t;
  endfunction

  task automatic push_exp(input int d, input exp_t e);
    if (d == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  task automatic pop_check(input int d, input logic [DW-1:0] r);
    exp_t e;
    int   sz;
    sz = (d == 0) ? sb0.size() : sb1.size();
    if (sz == 0) begin
      check("unexpected_result", 64'(r) + 64'd1, 64'd0);
      return;
    end
    e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
    check("result", 64'(r), e.exp);
    check("roundtrip", mont_mul(64'(r), 64'd1, e.q, log_r_of(d)), e.op_mod);
    if (e.chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'(log_r_of(d) + 1));
    if (d == 1 && b2b && last_hs[1] >= 0) check("b2b_spacing", 64'(cyc - last_hs[1]), 64'd17);
    last_hs[d] = cyc;
  endtask

  task automatic monitor_step(input int d);
    if (!rst_n) begin
      pv[d] = 1'b0;
      return;
    end
    // A result left unconsumed must still be presented, unchanged.
    if (pv[d] && !pr[d]) begin
      check("hold_valid", 64'(out_valid[d]), 64'd1);
      check("hold_res", 64'(res[d]), 64'(pres[d]));
    end
    if (out_valid[d] && out_ready[d]) pop_check(d, res[d]);
    pv[d]   = out_valid[d];
    pr[d]   = out_ready[d];
    pres[d] = res[d];
  endtask

  always @(negedge clk) monitor_step(0);
  always @(negedge clk) monitor_step(1);

  task automatic send(input int d, input logic [DW-1:0] o, input logic [DW-1:0] m, input bit lat);
    exp_t e;
    int   n;
    in_valid[d] = 1'b1;
    op[d]       = o;
    q[d]        = m;
    n = 0;
    @(negedge clk);
    while (!in_ready[d] && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready[d]) begin
      check("accept_timeout", 64'd0, 64'd1);
      in_valid[d] = 1'b0;
      return;
    end
    e.exp     = model(64'(o), 64'(m), log_r_of(d));
    e.op_mod  = 64'(o) % 64'(m);
    e.q       = 64'(m);
    e.acc_cyc = cyc;
    e.chk_lat = lat;
    push_exp(d, e);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    op[d]       = $urandom;
    q[d]        = $urandom;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (((d == 0) ? sb0.size() : sb1.size()) > 0 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("drain", 64'((d == 0) ? sb0.size() : sb1.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_operand(output logic [DW-1:0] o, output logic [DW-1:0] m);
    longint unsigned lim;
    m = $urandom | 32'd1;
    if (m < 3) m = 3;
    lim = 64'(m) * 2;
    if (lim > 64'h1_0000_0000) lim = 64'h1_0000_0000;
    o = DW'(64'($urandom) % lim);
  endtask

  initial begin
    logic [DW-1:0] ro, rq, held;
    int            n;
    bit            seen;
    bit            rand_done;

    last_hs[0] = -1;
    last_hs[1] = -1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      op[d]        = '0;
      q[d]         = '0;
      pv[d]        = 1'b0;
    end
    rst_n = 1'b0;

    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("rst_in_ready", 64'(in_ready[d]), 64'd1);
        check("rst_out_valid", 64'(out_valid[d]), 64'd0);
        check("rst_res", 64'(res[d]), 64'd0);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Kyber: first conversion plus edge cases, issued back to back.
    send(0, 32'd1, 32'd3329, 1'b1);
    send(0, 32'd0, 32'd3329, 1'b1);
    send(0, 32'd3328, 32'd3329, 1'b1);
    send(0, 32'd3334, 32'd3329, 1'b1);
    drain(0);

    // Dilithium.
    send(0, 32'd1, 32'd8380417, 1'b1);
    send(0, DW'($urandom_range(2 * 8380417 - 1, 0)), 32'd8380417, 1'b1);
    drain(0);

    // Backpressure: result held while inputs churn.
    out_ready[0] = 1'b0;
    send(0, 32'd1234, 32'd3329, 1'b0);
    n = 0;
    while (!out_valid[0] && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("bp_valid_seen", 64'(out_valid[0]), 64'd1);
    held = res[0];
    repeat (10) begin
      @(posedge clk);
      #1;
      in_valid[0] = 1'($urandom);
      op[0]       = $urandom;
      q[0]        = $urandom;
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready[0]), 64'd0);
      check("bp_res", 64'(res[0]), 64'(held));
    end
    @(posedge clk);
    #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_idle_ready", 64'(in_ready[0]), 64'd1);
    check("bp_idle_valid", 64'(out_valid[0]), 64'd0);
    drain(0);

    // Random operands with random consumer stalls.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          rand_operand(ro, rq);
          send(0, ro, rq, 1'b0);
        end
        drain(0);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready[0] = 1'($urandom);
        end
        out_ready[0] = 1'b1;
      end
    join
    drain(0);

    // Back-to-back on the LOG_R=16 instance.
    b2b = 1'b1;
    last_hs[1] = -1;
    send(1, 32'd1, 32'd3329, 1'b1);
    send(1, 32'd2, 32'd3329, 1'b1);
    send(1, 32'd3, 32'd3329, 1'b1);
    drain(1);
    b2b = 1'b0;

    // Reset in the middle of SHIFT with count == 5.
    send(0, 32'd77, 32'd3329, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb0.delete();
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready[0]), 64'd1);
    check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("postrst_in_ready", 64'(in_ready[0]), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid[0]) seen = 1'b1;
    end
    check("aborted_no_valid", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    send(0, 32'd2000, 32'd3329, 1'b1);
    drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
